// File: rtl/mul32_pkg.sv
// Shared multiplier constants and the stage-1 record of the final carry-propagate adder.
package mul32_pkg;

   localparam int unsigned PROD_W = 64;
   localparam int unsigned HALF_W = 32;

   typedef struct packed {
      logic [HALF_W-1:0] lo;
      logic              c32;
      logic [HALF_W-1:0] s_hi;
      logic [HALF_W-1:0] c_hi;
   } s1_t;

endpackage

// File: rtl/cpa32_adder.sv
// Combinational 32-bit adder with carry in/out; one instance per pipeline stage.
module cpa32_adder
   import mul32_pkg::*;
#(
   parameter int unsigned UUID = 0,
   parameter string       NAME = ""
) (
   input  logic [HALF_W-1:0] a_i,
   input  logic [HALF_W-1:0] b_i,
   input  logic              cin_i,
   output logic [HALF_W-1:0] sum_o,
   output logic              cout_o
);

   always_comb begin
      {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{HALF_W{1'b0}}, cin_i};
   end

endmodule

// File: rtl/mul32_final_cpa.sv
// Final carry-propagate adder of the 32x32 multiplier: two-stage split add of the
// compressor-tree sum/carry vectors with a valid/ready handshake on both sides.
module mul32_final_cpa
   import mul32_pkg::*;
#(
   parameter int unsigned UUID = 0,
   parameter string       NAME = ""
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PROD_W-1:0] wi_64bit_s,
   input  logic [PROD_W-1:0] wi_64bit_c,
   input  logic              wi_1bit_valid,
   output logic              wo_1bit_ready,
   output logic [PROD_W-1:0] wo_64bit_p,
   output logic              wo_1bit_zero,
   output logic              wo_1bit_valid,
   input  logic              wi_1bit_ready
);

   logic              s1_valid_q, s1_valid_d;
   s1_t               s1_q, s1_d;
   logic              s2_valid_q, s2_valid_d;
   logic [PROD_W-1:0] p_q, p_d;
   logic              zero_q, zero_d;

   logic              adv1, adv2, in_xfer;
   logic [HALF_W-1:0] lo_sum, hi_sum;
   logic              lo_cout, unused_hi_cout;

   cpa32_adder #(.UUID(UUID ^ 32'd1), .NAME("lo_add")) u_lo_add (
      .a_i    (wi_64bit_s[HALF_W-1:0]),
      .b_i    (wi_64bit_c[HALF_W-1:0]),
      .cin_i  (1'b0),
      .sum_o  (lo_sum),
      .cout_o (lo_cout)
   );

   cpa32_adder #(.UUID(UUID ^ 32'd2), .NAME("hi_add")) u_hi_add (
      .a_i    (s1_q.s_hi),
      .b_i    (s1_q.c_hi),
      .cin_i  (s1_q.c32),
      .sum_o  (hi_sum),
      .cout_o (unused_hi_cout)
   );

   // Ready looks only at downstream state, never at wi_1bit_valid.
   always_comb begin
      adv2          = !s2_valid_q || wi_1bit_ready;
      adv1          = !s1_valid_q || adv2;
      in_xfer       = wi_1bit_valid && adv1;
      wo_1bit_ready = adv1;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      s2_valid_d = s2_valid_q;
      p_d        = p_q;
      zero_d     = zero_q;
      if (adv1) begin
         s1_valid_d = in_xfer;
         if (in_xfer) begin
            s1_d.lo   = lo_sum;
            s1_d.c32  = lo_cout;
            s1_d.s_hi = wi_64bit_s[PROD_W-1:HALF_W];
            s1_d.c_hi = wi_64bit_c[PROD_W-1:HALF_W];
         end
      end
      if (adv2) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            p_d    = {hi_sum, s1_q.lo};
            zero_d = ({hi_sum, s1_q.lo} == '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_valid_q <= 1'b0;
         p_q        <= '0;
         zero_q     <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_q       <= s1_d;
         s2_valid_q <= s2_valid_d;
         p_q        <= p_d;
         zero_q     <= zero_d;
      end
   end

   assign wo_64bit_p    = p_q;
   assign wo_1bit_zero  = zero_q;
   assign wo_1bit_valid = s2_valid_q;

endmodule

// File: doc/mul32_final_cpa.md
MUL32_FINAL_CPA -- requirements
Module: mul32_final_cpa

Interface
REQ-001 SHALL have parameter UUID, default 0, instance identifier XORed into child UUIDs.
REQ-002 SHALL have parameter NAME, default "", instance label, no functional effect.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wi_64bit_s  input  64  sum vector from the 4:2 compressor tree.
REQ-006 SHALL have port wi_64bit_c  input  64  carry vector from the tree, already weight-aligned (product = S + C mod 2^64).
REQ-007 SHALL have port wi_1bit_valid  input  1  upstream presents a valid S/C pair.
REQ-008 SHALL have port wo_1bit_ready  output  1  block accepts the pair this cycle.
REQ-009 SHALL have port wo_64bit_p  output  64  final product.
REQ-010 SHALL have port wo_1bit_zero  output  1  product equals 0, aligned with wo_64bit_p.
REQ-011 SHALL have port wo_1bit_valid  output  1  wo_64bit_p and wo_1bit_zero are valid.
REQ-012 SHALL have port wi_1bit_ready  input  1  downstream accepts the product this cycle.

Function
REQ-013 SHALL implement a two-stage pipeline: S1 (low half add), S2 (high half add, output register).
REQ-014 S1 SHALL capture lo = S[31:0]+C[31:0] (32 bits), c32 = carry out of that add, S[63:32], C[63:32].
REQ-015 S2 SHALL capture p[31:0] = S1.lo and p[63:32] = (S1.S_hi + S1.C_hi + S1.c32) mod 2^32; carry out of bit 63 discarded.
REQ-016 wo_1bit_zero SHALL be registered in S2 as (p == 0), computed from the same values loaded into p.
REQ-017 Handshake: transfer in when wi_1bit_valid & wo_1bit_ready; transfer out when wo_1bit_valid & wi_1bit_ready.
REQ-018 adv2 = !s2_valid | wi_1bit_ready; adv1 = !s1_valid | adv2; wo_1bit_ready = adv1 (combinational, no dependence on wi_1bit_valid).
REQ-019 On adv1: s1_valid <= input transfer; S1 data loads only on input transfer. On adv2: s2_valid <= s1_valid; S2 data loads only when s1_valid.
REQ-020 Stages not advancing SHALL hold data and valid unchanged; wo_64bit_p and wo_1bit_zero stable while wo_1bit_valid & !wi_1bit_ready.
REQ-021 Latency SHALL be 2 cycles: pair accepted at edge N appears with wo_1bit_valid high after edge N+1.
REQ-022 Throughput SHALL be one product per cycle when wi_1bit_ready stays high; order preserved, no drop, no duplication.
REQ-023 With both stages full and wi_1bit_ready low, wo_1bit_ready SHALL be 0; at most 2 pairs in flight.
REQ-024 Simultaneous output transfer and input transfer with a full pipe SHALL shift both stages in the same edge.

Reset
REQ-025 rst high at an edge SHALL clear s1_valid, s2_valid, all S1/S2 data, wo_64bit_p = 0, wo_1bit_zero = 0; in-flight pairs discarded.
REQ-026 rst SHALL take priority over any simultaneous transfer; wo_1bit_ready = 1 the cycle after rst deasserts.

Structure
REQ-027 Shared package mul32_pkg SHALL hold constants PROD_W = 64 and HALF_W = 32 used by this block and the compressor tree.
REQ-028 One sub-module cpa32_adder (32-bit a + b + cin -> sum, cout, combinational) SHALL be instantiated twice, once per stage.
REQ-029 No other sub-modules; pipeline registers and handshake logic live in mul32_final_cpa.

Verification
REQ-030 S=0x00000000_FFFFFFFF, C=0x1, ready high -> p=0x00000001_00000000, zero=0, valid exactly 2 cycles after accept.
REQ-031 S=0xFFFFFFFF_FFFFFFFF, C=0x1 -> p=0x0, zero=1 (wrap, bit-64 carry dropped).
REQ-032 Three back-to-back pairs (S=1/2/3, C=0x10) with wi_1bit_ready=1 -> p=0x11,0x12,0x13 on consecutive cycles.
REQ-033 wi_1bit_ready=0, send two pairs -> wo_1bit_ready falls after second accept, p held stable; release ready -> both delivered in order, third accepted same edge.
REQ-034 rst pulsed while pipe full -> next cycle wo_1bit_valid=0, p=0, wo_1bit_ready=1; earlier pairs never emitted.
